// File: rtl/ifelse2_sweep_ctrl_if.sv
// Host-side control/result bundle for the ifelse2 sweep controller.
// Latency: none (wires only).
// Backpressure: none; start/abort are single-cycle pulses, results are levels.
interface ifelse2_sweep_ctrl_if;
    logic        start;
    logic        abort;
    logic [15:0] exp_tt;
    logic        busy;
    logic        done;
    logic [15:0] tt;
    logic        mismatch;
    logic [4:0]  err_cnt;
    logic [3:0]  first_err;

    // Host / self-test controller side
    modport master (
        output start, abort, exp_tt,
        input  busy, done, tt, mismatch, err_cnt, first_err
    );

    // Sweep controller side
    modport slave (
        input  start, abort, exp_tt,
        output busy, done, tt, mismatch, err_cnt, first_err
    );
endinterface

// File: rtl/ifelse2_sweep_ctrl.sv
// Walks {a,b,c,d} through all 16 vectors, samples y after SETTLE_CYCLES per vector, compares to exp_tt.
// Latency: 16*SETTLE_CYCLES cycles from accepted start to done.
// Backpressure: start ignored while busy; abort returns to IDLE on the next edge and wins over start.
module ifelse2_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ifelse2_sweep_ctrl_if.slave  host,
    input  logic                 y,
    output logic                 a,
    output logic                 b,
    output logic                 c,
    output logic                 d
);

    // Sample point of the settle counter; legal SETTLE_CYCLES is 1..15 so it fits 4 bits.
    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;         // current vector, also the registered a..d drive
    logic [3:0]  cnt, cnt_nxt;         // settle counter
    logic [15:0] exp_q, exp_nxt;       // expected table latched at start
    logic [15:0] tt_q, tt_nxt;
    logic [4:0]  err_q, err_nxt;
    logic [3:0]  first_q, first_nxt;
    logic        mis_q, mis_nxt;
    logic        miss;
    logic        start_ok;
    logic [4:0]  err_inc;

    // Abort has priority, so a simultaneous start/abort never launches a sweep.
    assign start_ok = host.start && !host.abort;
    assign err_inc  = err_q + 5'd1;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            err_q   <= '0;
            first_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            exp_q   <= exp_nxt;
            tt_q    <= tt_nxt;
            err_q   <= err_nxt;
            first_q <= first_nxt;
            mis_q   <= mis_nxt;
        end
    end

    // Next-state and next-datapath decode; everything holds unless a branch updates it.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        exp_nxt   = exp_q;
        tt_nxt    = tt_q;
        err_nxt   = err_q;
        first_nxt = first_q;
        mis_nxt   = mis_q;
        miss      = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_nxt = SWEEP;
                    exp_nxt   = host.exp_tt;
                    tt_nxt    = '0;
                    err_nxt   = '0;
                    first_nxt = '0;
                    mis_nxt   = 1'b0;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            SWEEP: begin
                if (host.abort) begin
                    // Partial tt/err_cnt/first_err stay visible; mismatch is only meaningful at DONE.
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (cnt == LAST_CNT) begin
                    tt_nxt[idx] = y;
                    miss        = (y != exp_q[idx]);
                    if (miss) begin
                        err_nxt = err_inc;
                        if (err_q == 5'd0) begin
                            first_nxt = idx;
                        end
                    end
                    cnt_nxt = '0;
                    if (idx == 4'd15) begin
                        state_nxt = DONE;
                        idx_nxt   = '0;
                        mis_nxt   = (err_nxt != 5'd0);
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // idx is forced to 0 outside SWEEP, so it doubles as the a..d drive register.
    assign {a, b, c, d}   = idx;
    assign host.busy      = (state == SWEEP);
    assign host.done      = (state == DONE);
    assign host.tt        = tt_q;
    assign host.mismatch  = mis_q;
    assign host.err_cnt   = err_q;
    assign host.first_err = first_q;

endmodule

// File: tb/tb_ifelse2_sweep_ctrl.sv
// Directed bench for ifelse2_sweep_ctrl with a behavioural ifelse2 stand-in selectable per test.
// Latency: checks exact cycle timing of vector walk and completion.
// Backpressure: exercises start-while-busy, abort, and start+abort collisions.
module tb_ifelse2_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifelse2_sweep_ctrl_if if1 ();
    ifelse2_sweep_ctrl_if if3 ();

    logic a1, b1, c1, d1, y1;
    logic a3, b3, c3, d3, y3;
    logic [3:0] vec1, vec3;
    int   mode;   // 0: y=d, 1: y=a, 2: y=a&d

    int nvec = 0;
    int nerr = 0;

    assign vec1 = {a1, b1, c1, d1};
    assign vec3 = {a3, b3, c3, d3};

    // Stand-in for the ifelse2 block under test.
    always_comb begin
        case (mode)
            0:       begin y1 = d1; y3 = d3; end
            1:       begin y1 = a1; y3 = a3; end
            default: begin y1 = a1 & d1; y3 = a3 & d3; end
        endcase
    end

    ifelse2_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .host(if1.slave), .y(y1),
        .a(a1), .b(b1), .c(c1), .d(d1)
    );

    ifelse2_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .host(if3.slave), .y(y3),
        .a(a3), .b(b3), .c(c3), .d(d3)
    );

    // Start pulse on dut1; returns at the negedge just after E0.
    task automatic pulse_start1(input logic [15:0] exp);
        @(negedge clk);
        if1.exp_tt = exp;
        if1.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if1.start  = 1'b0;
    endtask

    task automatic wait_done1(input int max_cycles);
        int n;
        n = 0;
        while (!if1.done && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (if1.done !== 1'b1) begin
            $display("FAIL wait_done1: done=%b after %0d cycles, want 1", if1.done, n);
            nerr++;
        end
    endtask

    task automatic test_reset();
        #1;
        nvec++;
        if ({if1.busy, if1.done, if1.mismatch, vec1} !== 7'b0) begin
            $display("FAIL reset_ctl: busy/done/mis/vec=%b want 0", {if1.busy, if1.done, if1.mismatch, vec1});
            nerr++;
        end
        nvec++;
        if ({if1.tt, if1.err_cnt, if1.first_err} !== 25'b0) begin
            $display("FAIL reset_res: tt=%h err=%0d first=%0d want 0", if1.tt, if1.err_cnt, if1.first_err);
            nerr++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_walk();
        mode = 0;
        pulse_start1(16'hAAAA);
        for (int k = 0; k < 16; k++) begin
            nvec++;
            if ({if1.busy, if1.done, vec1} !== {1'b1, 1'b0, 4'(k)}) begin
                $display("FAIL walk_vec%0d: busy/done/vec=%b want %b", k, {if1.busy, if1.done, vec1}, {2'b10, 4'(k)});
                nerr++;
            end
            @(negedge clk);
        end
        nvec++;
        if ({if1.busy, if1.done, vec1} !== 6'b010000) begin
            $display("FAIL walk_end: busy/done/vec=%b want 010000", {if1.busy, if1.done, vec1});
            nerr++;
        end
        nvec++;
        if (if1.tt !== 16'hAAAA || if1.mismatch !== 1'b0 || if1.err_cnt !== 5'd0) begin
            $display("FAIL walk_res: tt=%h mis=%b err=%0d want AAAA 0 0", if1.tt, if1.mismatch, if1.err_cnt);
            nerr++;
        end
    endtask

    task automatic test_single_err();
        mode = 0;
        pulse_start1(16'hAAAB);
        wait_done1(40);
        nvec++;
        if (if1.tt !== 16'hAAAA || if1.mismatch !== 1'b1 || if1.err_cnt !== 5'd1 || if1.first_err !== 4'd0) begin
            $display("FAIL single_err: tt=%h mis=%b err=%0d first=%0d want AAAA 1 1 0",
                     if1.tt, if1.mismatch, if1.err_cnt, if1.first_err);
            nerr++;
        end
    endtask

    task automatic test_y_a();
        mode = 1;
        pulse_start1(16'h0000);
        wait_done1(40);
        nvec++;
        if (if1.tt !== 16'hFF00 || if1.mismatch !== 1'b1 || if1.err_cnt !== 5'd8 || if1.first_err !== 4'd8) begin
            $display("FAIL y_a: tt=%h mis=%b err=%0d first=%0d want FF00 1 8 8",
                     if1.tt, if1.mismatch, if1.err_cnt, if1.first_err);
            nerr++;
        end
    endtask

    task automatic test_done_restart();
        // abort while DONE must not disturb the held results
        @(negedge clk);
        if1.abort = 1'b1;
        @(negedge clk);
        if1.abort = 1'b0;
        nvec++;
        if (if1.done !== 1'b1 || if1.tt !== 16'hFF00 || if1.err_cnt !== 5'd8 || if1.mismatch !== 1'b1) begin
            $display("FAIL abort_in_done: done=%b tt=%h err=%0d mis=%b want 1 FF00 8 1",
                     if1.done, if1.tt, if1.err_cnt, if1.mismatch);
            nerr++;
        end
        mode = 1;
        pulse_start1(16'hFF00);
        nvec++;
        if ({if1.busy, if1.done, if1.mismatch} !== 3'b100 || if1.tt !== 16'h0 ||
            if1.err_cnt !== 5'd0 || if1.first_err !== 4'd0) begin
            $display("FAIL restart_clear: busy/done/mis=%b tt=%h err=%0d first=%0d want 100 0 0 0",
                     {if1.busy, if1.done, if1.mismatch}, if1.tt, if1.err_cnt, if1.first_err);
            nerr++;
        end
        wait_done1(40);
        nvec++;
        if (if1.tt !== 16'hFF00 || if1.mismatch !== 1'b0 || if1.err_cnt !== 5'd0) begin
            $display("FAIL restart_res: tt=%h mis=%b err=%0d want FF00 0 0", if1.tt, if1.mismatch, if1.err_cnt);
            nerr++;
        end
    endtask

    task automatic test_settle3();
        mode = 2;
        @(negedge clk);
        if3.exp_tt = 16'hAA00;
        if3.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if3.start  = 1'b0;
        for (int k = 0; k < 48; k++) begin
            nvec++;
            if ({if3.busy, vec3} !== {1'b1, 4'(k / 3)}) begin
                $display("FAIL s3_vec_cyc%0d: busy/vec=%b want %b", k, {if3.busy, vec3}, {1'b1, 4'(k / 3)});
                nerr++;
            end
            @(negedge clk);
        end
        nvec++;
        if ({if3.busy, if3.done, vec3} !== 6'b010000 || if3.tt !== 16'hAA00 ||
            if3.mismatch !== 1'b0 || if3.err_cnt !== 5'd0) begin
            $display("FAIL s3_end: busy/done/vec=%b tt=%h mis=%b err=%0d want 010000 AA00 0 0",
                     {if3.busy, if3.done, vec3}, if3.tt, if3.mismatch, if3.err_cnt);
            nerr++;
        end
    endtask

    task automatic test_abort();
        mode = 0;
        pulse_start1(16'hAAAA);
        repeat (4) @(negedge clk);
        if1.abort = 1'b1;                 // sampled at E0+5
        @(posedge clk);
        @(negedge clk);
        if1.abort = 1'b0;
        nvec++;
        if ({if1.busy, if1.done, if1.mismatch, vec1} !== 7'b0) begin
            $display("FAIL abort_ctl: busy/done/mis/vec=%b want 0", {if1.busy, if1.done, if1.mismatch, vec1});
            nerr++;
        end
        nvec++;
        if (if1.tt !== 16'h000A || if1.err_cnt !== 5'd0) begin
            $display("FAIL abort_partial: tt=%h err=%0d want 000A 0", if1.tt, if1.err_cnt);
            nerr++;
        end
        // start and abort together from IDLE
        if1.start = 1'b1;
        if1.abort = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        if1.abort = 1'b0;
        @(negedge clk);
        nvec++;
        if ({if1.busy, if1.done, vec1} !== 6'b0 || if1.tt !== 16'h000A) begin
            $display("FAIL start_abort: busy/done/vec=%b tt=%h want 0 000A", {if1.busy, if1.done, vec1}, if1.tt);
            nerr++;
        end
    endtask

    task automatic test_start_ignored();
        mode = 0;
        pulse_start1(16'h5555);
        for (int k = 0; k < 16; k++) begin
            if1.start  = (k == 7);
            if1.exp_tt = 16'hAAAA;
            nvec++;
            if ({if1.busy, vec1} !== {1'b1, 4'(k)}) begin
                $display("FAIL ign_vec%0d: busy/vec=%b want %b", k, {if1.busy, vec1}, {1'b1, 4'(k)});
                nerr++;
            end
            @(negedge clk);
        end
        if1.start = 1'b0;
        nvec++;
        if ({if1.busy, if1.done} !== 2'b01 || if1.tt !== 16'hAAAA || if1.err_cnt !== 5'd16 || if1.first_err !== 4'd0) begin
            $display("FAIL ign_end: busy/done=%b tt=%h err=%0d first=%0d want 01 AAAA 16 0",
                     {if1.busy, if1.done}, if1.tt, if1.err_cnt, if1.first_err);
            nerr++;
        end
    endtask

    task automatic test_async_reset();
        mode = 0;
        pulse_start1(16'h0000);
        repeat (3) @(negedge clk);
        nvec++;
        if (if1.tt !== 16'h0002 || if1.err_cnt !== 5'd1) begin
            $display("FAIL pre_reset: tt=%h err=%0d want 0002 1", if1.tt, if1.err_cnt);
            nerr++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({if1.busy, if1.done, if1.mismatch, vec1} !== 7'b0 ||
            {if1.tt, if1.err_cnt, if1.first_err} !== 25'b0) begin
            $display("FAIL async_reset: busy/done/mis/vec=%b tt=%h err=%0d first=%0d want all 0",
                     {if1.busy, if1.done, if1.mismatch, vec1}, if1.tt, if1.err_cnt, if1.first_err);
            nerr++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        mode       = 0;
        if1.start  = 1'b0;
        if1.abort  = 1'b0;
        if1.exp_tt = 16'h0;
        if3.start  = 1'b0;
        if3.abort  = 1'b0;
        if3.exp_tt = 16'h0;
        test_reset();
        test_walk();
        test_single_err();
        test_y_a();
        test_done_restart();
        test_settle3();
        test_abort();
        test_start_ignored();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
